// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the pipelined register file.
// Field extraction is width-agnostic so the top can slice any packed port bus.
package regfile_pkg;

    localparam int REG_DATA_W  = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int REG_ZERO    = 0;

    localparam int FIELD_MAX_W = 256;
    localparam int FIELD_OUT_W = 64;

    function automatic logic [FIELD_OUT_W-1:0] getField(
        input logic [FIELD_MAX_W-1:0] vec,
        input int                     idx,
        input int                     width
    );
        logic [FIELD_MAX_W-1:0] shifted;
        logic [FIELD_OUT_W-1:0] mask;
        shifted = vec >> (idx * width);
        mask    = (FIELD_OUT_W'(1) << width) - FIELD_OUT_W'(1);
        return shifted[FIELD_OUT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Register-file bus: packed read ports, writeback port and scoreboard controls.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NUM_RD = 2
) ();

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     alloc_en;
    logic [ADDR_W-1:0]        alloc_addr;
    logic                     flush;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: zero register, writeback bypass, then array value.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] memData,
    input  logic              busyBit,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    logic isZero;
    logic hit;

    always_comb begin
        isZero = (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));
        hit    = (BYPASS != 0) && wrEn && (wrAddr == addr);
        if (isZero) begin
            data = '0;
        end else if (hit) begin
            data = wrData;
        end else begin
            data = memData;
        end
        // The producer retiring this cycle is already visible, so it no longer blocks.
        busy = busyBit && !isZero && !hit;
    end

endmodule

// File: rtl/regfile_bypass.sv
// Parametrised register file with same-cycle bypass, zero register and a
// per-register pending-write scoreboard for RAW hazard detection in decode.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic     clk,
    input logic     rst,
    regfile_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busyVec;
    logic              wrLive;
    logic              wrToZero;

    // Bypass must stay quiet while reset holds the outputs at zero.
    assign wrLive   = bus.wr_en && !rst;
    assign wrToZero = (ZERO_REG != 0) && (bus.wr_addr == ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (bus.wr_en && !wrToZero) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Later assignments win: alloc overrides a same-address writeback clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busyVec <= '0;
        end else if (bus.flush) begin
            busyVec <= '0;
        end else begin
            if (bus.wr_en) begin
                busyVec[bus.wr_addr] <= 1'b0;
            end
            if (bus.alloc_en) begin
                busyVec[bus.alloc_addr] <= 1'b1;
            end
            if (ZERO_REG != 0) begin
                busyVec[REG_ZERO] <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : gPort
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busyOut;

        assign addr = ADDR_W'(getField(FIELD_MAX_W'(bus.rd_addr), i, ADDR_W));

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) uPort (
            .addr    (addr),
            .memData (mem[addr]),
            .busyBit (busyVec[addr]),
            .wrEn    (wrLive),
            .wrAddr  (bus.wr_addr),
            .wrData  (bus.wr_data),
            .data    (data),
            .busy    (busyOut)
        );

        assign bus.rd_data[i*DATA_W +: DATA_W] = data;
        assign bus.rd_busy[i]                  = busyOut;
    end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Parametrised successor to the single-cycle MIPS RegisterFile, built for the pipelined datapath.
- Generalises data width, register count and read-port count.
- Adds same-cycle write-to-read bypass, a hardwired zero register and asynchronous reset of the storage.
- Adds a per-register pending-write scoreboard that lets decode detect RAW hazards.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1, a write in the current cycle is visible on matching read ports in that same cycle.

Ports:
- clk  in  1  Rising-edge clock for all state.
- rst  in  1  Asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  Read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  Read data, packed the same way as rd_addr.
- rd_busy  out  NUM_RD  Per-port flag: the addressed register has an outstanding write.
- wr_en  in  1  Write enable; writeback stage, equivalent of RegWrite.
- wr_addr  in  ADDR_W  Write address.
- wr_data  in  DATA_W  Write data.
- alloc_en  in  1  Issue stage marks alloc_addr as having a pending producer.
- alloc_addr  in  ADDR_W  Register to mark busy.
- flush  in  1  Synchronous clear of all busy bits (pipeline flush); register contents are kept.

Behaviour:
- Reset (async, rst=1):
  - All 2**ADDR_W registers and busy bits go to 0 immediately.
  - While rst=1, rd_data is all zero and rd_busy is 0.
  - wr_en, alloc_en and flush are ignored, and bypass is suppressed.
- Write:
  - On the rising clk edge with wr_en=1, mem[wr_addr] <= wr_data.
  - Writes to address 0 are discarded when ZERO_REG=1.
- Read (combinational, zero latency), per port i:
  - If ZERO_REG=1 and rd_addr_i==0, rd_data_i = 0.
  - Else if BYPASS=1, wr_en=1 and wr_addr==rd_addr_i, rd_data_i = wr_data.
  - Else rd_data_i = mem[rd_addr_i].
- Multiple ports may read the same address and receive identical data.
- Scoreboard: one busy bit per register, updated on the clk edge. Priority, highest first:
  - flush=1: all bits are cleared; a same-cycle alloc is also discarded.
  - alloc_en=1: busy[alloc_addr] <= 1.
  - wr_en=1: busy[wr_addr] <= 0, unless wr_addr==alloc_addr with alloc_en=1. A new producer wins, so the bit stays 1.
  - Alloc and write to different addresses in the same cycle both take effect.
- rd_busy_i = busy[rd_addr_i] & ~(wr_en & wr_addr==rd_addr_i & BYPASS), forced to 0 for address 0 when ZERO_REG=1. A register being written back this cycle therefore reads not-busy when bypass is enabled.
- Allocating an already-busy register leaves it busy (no counting). Writing a non-busy register is legal; its busy bit stays 0.
- rst asserted mid-operation overrides everything. After rst deasserts, the first write lands on the next clk edge.
- Timing: no clock-gating, and no combinational path from rst to storage other than the async clear.

Decomposition:
- Shared package regfile_pkg:
  - Default constants REG_DATA_W=32, REG_ADDR_W=5, REG_ZERO=0 (address of the zero register).
  - A function that extracts field i from a packed vector.
- Sub-module regfile_read_port, instantiated NUM_RD times in a generate loop:
  - Inputs: addr, the memory read value, the busy bit, and the write bypass signals.
  - Outputs: data, busy.
  - Implements the zero / bypass / array mux.
- The storage and scoreboard stay in the top module.

Test Plan:
- Reset then read: assert rst with regs previously written, read r5 and r31 -> rd_data=0, rd_busy=0. Deassert rst, write r5=64 -> next cycle r5 reads 64.
- Zero register: wr_en=1, wr_addr=0, wr_data=0xDEADBEEF; read r0 on both ports in the same and next cycle -> 0. alloc r0 -> rd_busy stays 0.
- Bypass: wr_en=1, wr_addr=12, wr_data=0x1234 while rd_addr port0=12, port1=10 -> port0=0x1234 in that cycle, port1=old r10. With BYPASS=0, port0 shows the old r12 until the next cycle.
- Scoreboard: alloc r9, next cycle read r9 -> busy=1. Write r9=7 -> busy=0 in that cycle and data=7. Next cycle busy=0.
- Simultaneous events:
  - alloc r3 and wr r3 in the same cycle -> r3 busy=1 and data updated.
  - alloc r4 and wr r6 in the same cycle -> r4 busy, r6 clear.
  - flush together with alloc r8 -> all busy=0.
- Async reset mid-write: rst pulse between clk edges while wr_en=1 -> storage is cleared immediately and the pending write is not committed. NUM_RD=4 regression repeats the bypass case on all ports.
